// File: rtl/mul_seq.sv
// Iterative shift-add multiplier supporting MUL, MLA, UMULL and SMULL with a start/done handshake.
// Optional build macro MUL_SEQ_EARLY_OUT_EN ends CALC as soon as the remaining multiplier is zero.
module mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             flag_n,
    output logic             flag_z
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MLA   = 2'b01;
    localparam logic [1:0] OP_UMULL = 2'b10;
    localparam logic [1:0] OP_SMULL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [1:0]         op_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      cnt;
    logic               sign_q;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [2*WIDTH-1:0] fix_product;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic               fix_n;
    logic               fix_z;

    assign accept = start && ((state == IDLE) || (state == DONE));
    assign busy   = (state == CALC) || (state == FIX);
    assign done   = (state == DONE);

`ifdef MUL_SEQ_EARLY_OUT_EN
    assign last_iter = (mplier[WIDTH-1:1] == '0) || (cnt == CW'(WIDTH - 1));
`else
    assign last_iter = (cnt == CW'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SMULL runs the unsigned engine on magnitudes; the sign is reapplied in FIX.
    always_comb begin
        a_sel = a;
        b_sel = b;
        if (op == OP_SMULL) begin
            if (a[WIDTH-1]) a_sel = -a;
            if (b[WIDTH-1]) b_sel = -b;
        end
    end

    always_comb begin
        fix_product = product;
        fix_lo      = '0;
        fix_hi      = '0;
        fix_n       = 1'b0;
        fix_z       = 1'b0;
        if ((op_q == OP_SMULL) && sign_q) begin
            fix_product = -product;
        end
        case (op_q)
            OP_MUL, OP_MLA: begin
                fix_lo = (op_q == OP_MLA) ? (product[WIDTH-1:0] + acc_q) : product[WIDTH-1:0];
                fix_hi = '0;
                fix_n  = fix_lo[WIDTH-1];
                fix_z  = (fix_lo == '0);
            end
            default: begin
                fix_lo = fix_product[WIDTH-1:0];
                fix_hi = fix_product[2*WIDTH-1:WIDTH];
                fix_n  = fix_product[2*WIDTH-1];
                fix_z  = (fix_product == '0);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= OP_MUL;
            acc_q     <= '0;
            mplier    <= '0;
            mcand     <= '0;
            product   <= '0;
            cnt       <= '0;
            sign_q    <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= op;
                acc_q   <= acc;
                mcand   <= {{WIDTH{1'b0}}, a_sel};
                mplier  <= b_sel;
                sign_q  <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
                product <= '0;
                cnt     <= '0;
            end else if (state == CALC) begin
                if (mplier[0]) product <= product + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
            end
            if (state == FIX) begin
                result_lo <= fix_lo;
                result_hi <= fix_hi;
                flag_n    <= fix_n;
                flag_z    <= fix_z;
            end
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomized bench for mul_seq (WIDTH = 32, default build without early-out).
// Expected results come from a 64-bit arithmetic reference model of each operation.
module tb_mul_seq;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [W-1:0]  acc = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result_lo;
    logic [W-1:0]  result_hi;
    logic          flag_n;
    logic          flag_z;

    int n_compared = 0;
    int n_failed   = 0;

    mul_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc       (acc),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: full-width arithmetic, then the architectural view of each op.
    task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z, output logic [W-1:0] lo, output logic [W-1:0] hi,
                         output logic n, output logic zf);
        logic [63:0] p;
        logic [63:0] xs;
        logic [63:0] ys;
        case (o)
            2'b00: p = {32'b0, x * y};
            2'b01: p = {32'b0, x * y + z};
            2'b10: p = {32'b0, x} * {32'b0, y};
            default: begin
                xs = {{32{x[W-1]}}, x};
                ys = {{32{y[W-1]}}, y};
                p  = xs * ys;
            end
        endcase
        lo = p[31:0];
        hi = p[63:32];
        if (o[1]) begin
            n  = p[63];
            zf = (p == 64'd0);
        end else begin
            n  = p[31];
            zf = (p[31:0] == 32'd0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [W-1:0] z);
        op    = o;
        a     = x;
        b     = y;
        acc   = z;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Entered in cycle 1 after the accept edge; returns the cycle in which done was seen.
    task automatic waitDone(output int lat, output logic busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            step();
            lat++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] z);
        logic [W-1:0] e_lo;
        logic [W-1:0] e_hi;
        logic         e_n;
        logic         e_z;
        int           lat;
        logic         busy_ok;
        model(o, x, y, z, e_lo, e_hi, e_n, e_z);
        applyStimulus(o, x, y, z);
        waitDone(lat, busy_ok);
        checkOutput({tag, " latency"}, 64'(lat), 64'(LAT));
        checkOutput({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        checkOutput({tag, " busy_at_done"}, 64'(busy), 64'd0);
        checkOutput({tag, " result_lo"}, 64'(result_lo), 64'(e_lo));
        checkOutput({tag, " result_hi"}, 64'(result_hi), 64'(e_hi));
        checkOutput({tag, " flag_n"}, 64'(flag_n), 64'(e_n));
        checkOutput({tag, " flag_z"}, 64'(flag_z), 64'(e_z));
    endtask

    initial begin
        logic [1:0]   r_op;
        logic [W-1:0] r_a;
        logic [W-1:0] r_b;
        logic [W-1:0] r_acc;
        logic [W-1:0] e_lo;
        logic [W-1:0] e_hi;
        logic         e_n;
        logic         e_z;
        int           lat;
        logic         busy_ok;
        logic         saw_done;

        $display("[TB] reset");
        reset = 1'b0;
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        reset = 1'b1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset result_lo", 64'(result_lo), 64'd0);
        checkOutput("reset result_hi", 64'(result_hi), 64'd0);
        checkOutput("reset flags", 64'({flag_n, flag_z}), 64'd0);
        step();

        $display("[TB] directed vectors");
        runAndCheck("umull_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        step();
        checkOutput("done_pulse_single", 64'(done), 64'd0);
        checkOutput("result_held", 64'(result_lo), 64'h1);
        runAndCheck("smull_neg2x3", 2'b11, 32'hFFFF_FFFE, 32'd3, 32'h0);
        runAndCheck("smull_minxmin", 2'b11, 32'h8000_0000, 32'h8000_0000, 32'h0);
        runAndCheck("mla_7x6", 2'b01, 32'd7, 32'd6, 32'h10);
        runAndCheck("mul_zero", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0);
        runAndCheck("smull_zero_neg", 2'b11, 32'h0, 32'hFFFF_FFF0, 32'h0);

        $display("[TB] start while busy is ignored");
        step();
        model(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, e_lo, e_hi, e_n, e_z);
        applyStimulus(2'b10, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        lat      = 1;
        saw_done = 1'b0;
        while (done !== 1'b1 && lat < 200) begin
            if (lat == 5 || lat == 20) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 32'd3;
                b     = 32'd5;
                acc   = 32'd1;
            end else begin
                start = 1'b0;
            end
            step();
            lat++;
        end
        start = 1'b0;
        checkOutput("busy_start latency", 64'(lat), 64'(LAT));
        checkOutput("busy_start result_lo", 64'(result_lo), 64'(e_lo));
        checkOutput("busy_start result_hi", 64'(result_hi), 64'(e_hi));
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("busy_start no_extra_done", 64'(saw_done), 64'd0);

        $display("[TB] back-to-back and randomized");
        runAndCheck("b2b_first", 2'b10, 32'hDEAD_BEEF, 32'h0000_0003, 32'h0);
        runAndCheck("b2b_second", 2'b11, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        for (int i = 0; i < 24; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_a   = $urandom;
            r_b   = $urandom;
            r_acc = $urandom;
            if (i % 6 == 0) r_b = 32'h8000_0000;
            if (i % 6 == 1) r_a = 32'h8000_0000;
            runAndCheck($sformatf("rand%0d", i), r_op, r_a, r_b, r_acc);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        $display("[TB] reset during CALC");
        step();
        applyStimulus(2'b10, 32'hFFFF_FFFF, 32'h0000_0007, 32'h0);
        for (int c = 1; c < 10; c++) step();
        reset = 1'b0;
        start = 1'b1;
        step();
        reset = 1'b1;
        start = 1'b0;
        checkOutput("midreset busy", 64'(busy), 64'd0);
        checkOutput("midreset done", 64'(done), 64'd0);
        checkOutput("midreset result_lo", 64'(result_lo), 64'd0);
        checkOutput("midreset result_hi", 64'(result_hi), 64'd0);
        checkOutput("midreset flags", 64'({flag_n, flag_z}), 64'd0);
        saw_done = 1'b0;
        busy_ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done === 1'b1) saw_done = 1'b1;
            if (busy === 1'b1) busy_ok = 1'b1;
        end
        checkOutput("midreset no_done", 64'(saw_done), 64'd0);
        checkOutput("midreset no_busy", 64'(busy_ok), 64'd0);

        runAndCheck("after_reset", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised multi-cycle integer multiplier for the multicycle processor's execute path. It generalises the single-cycle MUL datapath support to configurable operand width. It adds multiply-accumulate, unsigned long and signed long products via an iterative shift-add engine with a start/done handshake. The controller launches it from the execute state and stalls until `done`, then writes `result_lo`/`result_hi` through the two register-file write ports.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; legal range 4–64; full product is 2*WIDTH bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  launch request; accepted only in IDLE or DONE.
- op  in  2  operation: 00 MUL, 01 MLA, 10 UMULL, 11 SMULL; captured at accept.
- a  in  WIDTH  multiplicand (Rm); captured at accept.
- b  in  WIDTH  multiplier (Rs); captured at accept.
- acc  in  WIDTH  addend for MLA (Ra); captured at accept; ignored for other ops.
- busy  out  1  high in CALC and FIX.
- done  out  1  single-cycle pulse; results valid in that cycle and held afterwards.
- result_lo  out  WIDTH  low product word (Rd for MUL/MLA, RdLo for long ops).
- result_hi  out  WIDTH  high product word (RdHi); forced 0 for MUL/MLA.
- flag_n  out  1  negative flag of the architecturally visible result.
- flag_z  out  1  zero flag of the architecturally visible result.

## Operation
- States: IDLE, CALC, FIX, DONE. IDLE→CALC on start. CALC→FIX after the last iteration. FIX→DONE always. DONE→CALC on start, otherwise DONE→IDLE.
- Accept: latch op and acc. For SMULL, latch |a| and |b| as WIDTH-bit unsigned magnitudes and record sign = a[W-1]^b[W-1]. For all other ops, latch a and b raw. |−2^(W-1)| = 2^(W-1), which fits unsigned. Clear the 2W-bit product register and the iteration counter.
- CALC, per cycle: if multiplier LSB = 1, product += multiplicand << i. Multiplier shifts right by one. Counter increments. WIDTH iterations, unless early-out is enabled (see Configuration).
- FIX: for SMULL with sign = 1, product = two's-complement negate of the full 2W bits. For MLA, result_lo = product[W-1:0] + acc, modulo 2^W. Load the output registers.
- Flags: MUL/MLA: N = result_lo[W-1], Z = (result_lo == 0). UMULL/SMULL: N = result_hi[W-1], Z = (entire 2W-bit result == 0).
- start while busy: ignored; the in-flight operation is unaffected.
- Outputs hold their last values from DONE through IDLE until the next FIX.
- Reset low in any cycle, including mid-CALC: the next state is IDLE. busy = 0, done = 0, result_lo = result_hi = 0, flag_n = flag_z = 0, and all internal registers are cleared. Reset wins over a simultaneous start.

## Timing
- Start accepted at edge 0. busy is high from cycle 1. CALC occupies cycles 1..WIDTH, FIX is cycle WIDTH+1, and done pulses in cycle WIDTH+2 with busy low.
- Fixed latency without early-out: WIDTH+2 cycles from accept to done (34 for WIDTH = 32).
- Back-to-back: a start in the DONE cycle is accepted. The next done follows WIDTH+2 cycles later, so there are no idle bubbles.
- done is never high for more than one consecutive cycle per accepted start.

## Configuration
- MUL_SEQ_EARLY_OUT_EN defined: CALC exits to FIX at the end of the first iteration where the remaining shifted multiplier is zero. Iterations = max(1, position of the highest set bit of the latched multiplier + 1). Latency = iterations + 2.
- Undefined: always WIDTH iterations and fixed WIDTH+2 latency. Results are identical in both builds.

## Test plan
- WIDTH = 32, UMULL a = 0xFFFFFFFF, b = 0xFFFFFFFF -> done at cycle 34, result_hi = 0xFFFFFFFE, result_lo = 0x00000001, N = 1, Z = 0.
- SMULL a = 0xFFFFFFFE (−2), b = 3 -> result_hi = 0xFFFFFFFF, result_lo = 0xFFFFFFFA, N = 1. SMULL 0x80000000 × 0x80000000 -> result_hi = 0x40000000, result_lo = 0, N = 0, Z = 0.
- MLA a = 7, b = 6, acc = 0x10 -> result_lo = 0x3A, result_hi = 0. MUL 0x10000 × 0x10000 -> result_lo = 0, Z = 1, N = 0.
- Start UMULL, pulse start again with different operands at cycles 5 and 20 -> one done at cycle 34 with the original result. A start in the DONE cycle -> next done 34 cycles later.
- Reset low at cycle 10 of a CALC -> next cycle busy = 0, done = 0, results and flags = 0. No done pulse follows.
- With MUL_SEQ_EARLY_OUT_EN: UMULL a = 5, b = 1 -> done at cycle 3, result_lo = 5. b = 0 -> done at cycle 3, Z = 1. b = 0x80000000 -> done at cycle 34.
